// File: rtl/dsp_core.sv
// dsp_core: per-sample programmable DSP engine with a 3-stage RD/EX/WB pipeline.
// A start pulse snapshots the input channels and runs the program from address 0.
module dsp_core #(
    parameter int unsigned DATA_W    = 36,
    parameter int unsigned N_IO      = 8,
    parameter int unsigned IMEM_AW   = 8,
    parameter int unsigned DMEM_AW   = 10,
    parameter int unsigned FRAC_BITS = 27
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [N_IO-1:0][DATA_W-1:0] inputs,
    output logic [N_IO-1:0][DATA_W-1:0] outputs,
    input  logic                        imem_we,
    input  logic [IMEM_AW-1:0]          imem_addr,
    input  logic [DATA_W-1:0]           imem_wdata,
    output logic                        busy,
    output logic [2:0]                  dbg_valid,
    output logic [2:0][IMEM_AW-1:0]     dbg_pc,
    output logic [2:0][DATA_W-1:0]      dbg_instr,
    output logic [2:0][5:0]             dbg_opcode,
    output logic [DATA_W-1:0]           dbg_op_a,
    output logic [DATA_W-1:0]           dbg_op_b,
    output logic                        dbg_wr_en,
    output logic [DMEM_AW-1:0]          dbg_wr_addr,
    output logic [DATA_W-1:0]           dbg_wr_data
);

    localparam int unsigned IO_AW = $clog2(N_IO);
    localparam int unsigned IMM_W = 2 * DMEM_AW;
    localparam int unsigned OP_W  = DATA_W - 3 * DMEM_AW;
    localparam logic [DMEM_AW-1:0] OutBase = DMEM_AW'(N_IO);
    localparam logic [DMEM_AW-1:0] RamBase = DMEM_AW'(2 * N_IO);

    localparam logic [OP_W-1:0] OpAdd  = OP_W'(1);
    localparam logic [OP_W-1:0] OpSub  = OP_W'(2);
    localparam logic [OP_W-1:0] OpMul  = OP_W'(3);
    localparam logic [OP_W-1:0] OpAnd  = OP_W'(4);
    localparam logic [OP_W-1:0] OpOr   = OP_W'(5);
    localparam logic [OP_W-1:0] OpXor  = OP_W'(6);
    localparam logic [OP_W-1:0] OpMov  = OP_W'(7);
    localparam logic [OP_W-1:0] OpLdi  = OP_W'(8);
    localparam logic [OP_W-1:0] OpHalt = OP_W'(9);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e                      state_q, state_d;
    logic [IMEM_AW-1:0]          pc_q, pc_d;
    logic [N_IO-1:0][DATA_W-1:0] snap_q, snap_d;
    logic [N_IO-1:0][DATA_W-1:0] out_q, out_d;

    logic                        ex_valid_q, ex_valid_d;
    logic [IMEM_AW-1:0]          ex_pc_q, ex_pc_d;
    logic [DATA_W-1:0]           ex_instr_q, ex_instr_d;
    logic [DATA_W-1:0]           ex_a_q, ex_a_d;
    logic [DATA_W-1:0]           ex_b_q, ex_b_d;

    logic                        wb_valid_q, wb_valid_d;
    logic                        wb_we_q, wb_we_d;
    logic [IMEM_AW-1:0]          wb_pc_q, wb_pc_d;
    logic [DATA_W-1:0]           wb_instr_q, wb_instr_d;
    logic [DMEM_AW-1:0]          wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0]           wb_data_q, wb_data_d;

    logic [DATA_W-1:0]           imem_q [2**IMEM_AW];
    logic [DATA_W-1:0]           ram_q  [2**DMEM_AW];

    // RD stage: fetch and operand read
    logic                        rd_valid;
    logic [DATA_W-1:0]           rd_instr;
    logic [OP_W-1:0]             rd_op;
    logic [1:0][DMEM_AW-1:0]     rd_addr;
    logic [1:0][DATA_W-1:0]      rd_data;

    assign rd_valid   = (state_q == StRun);
    assign rd_instr   = imem_q[pc_q];
    assign rd_op      = rd_instr[DATA_W-1 -: OP_W];
    assign rd_addr[0] = rd_instr[IMM_W-1:DMEM_AW];
    assign rd_addr[1] = rd_instr[DMEM_AW-1:0];

    // Write-first: a read of the address retiring this cycle sees the new value
    always_comb begin
        rd_data = '0;
        for (int p = 0; p < 2; p++) begin
            if (rd_addr[p] < OutBase) begin
                rd_data[p] = snap_q[rd_addr[p][IO_AW-1:0]];
            end else if (rd_addr[p] < RamBase) begin
                rd_data[p] = out_q[rd_addr[p][IO_AW-1:0]];
            end else begin
                rd_data[p] = ram_q[rd_addr[p]];
            end
            if (wb_we_q && (wb_addr_q == rd_addr[p])) begin
                rd_data[p] = wb_data_q;
            end
        end
    end

    // EX stage
    logic [OP_W-1:0]             ex_op;
    logic [DMEM_AW-1:0]          ex_rw, ex_ra, ex_rb;
    logic [DATA_W-1:0]           op_a, op_b, alu_res;
    logic                        alu_wr, ex_we;
    logic signed [2*DATA_W-1:0]  mul_a, mul_b, mul_p;

    assign ex_op = ex_instr_q[DATA_W-1 -: OP_W];
    assign ex_rw = ex_instr_q[3*DMEM_AW-1:IMM_W];
    assign ex_ra = ex_instr_q[IMM_W-1:DMEM_AW];
    assign ex_rb = ex_instr_q[DMEM_AW-1:0];

    always_comb begin
        op_a = ex_a_q;
        op_b = ex_b_q;
        if (wb_we_q && (wb_addr_q == ex_ra)) op_a = wb_data_q;
        if (wb_we_q && (wb_addr_q == ex_rb)) op_b = wb_data_q;
    end

    always_comb begin
        alu_res = '0;
        alu_wr  = 1'b1;
        mul_a   = {{DATA_W{op_a[DATA_W-1]}}, op_a};
        mul_b   = {{DATA_W{op_b[DATA_W-1]}}, op_b};
        mul_p   = mul_a * mul_b;
        case (ex_op)
            OpAdd:   alu_res = op_a + op_b;
            OpSub:   alu_res = op_a - op_b;
            OpMul:   alu_res = DATA_W'(mul_p >>> FRAC_BITS);
            OpAnd:   alu_res = op_a & op_b;
            OpOr:    alu_res = op_a | op_b;
            OpXor:   alu_res = op_a ^ op_b;
            OpMov:   alu_res = op_a;
            OpLdi:   alu_res = {{(DATA_W-IMM_W){ex_instr_q[IMM_W-1]}}, ex_instr_q[IMM_W-1:0]};
            default: alu_wr  = 1'b0;
        endcase
    end

    // Writes to the input snapshot region are dropped here so they never forward
    assign ex_we = ex_valid_q && alu_wr && (ex_rw >= OutBase);

    // Control FSM
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            StIdle: ;
            StRun: begin
                pc_d = pc_q + 1'b1;
                if ((rd_op == OpHalt) || (pc_q == '1)) state_d = StDrain;
            end
            StDrain: begin
                if (!ex_valid_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (start) begin
            state_d = StRun;
            pc_d    = '0;
        end
    end

    // Pipeline and I/O next state
    always_comb begin
        snap_d = start ? inputs : snap_q;
        out_d  = out_q;
        if (wb_we_q && (wb_addr_q < RamBase)) out_d[wb_addr_q[IO_AW-1:0]] = wb_data_q;

        ex_valid_d = rd_valid && !start;
        ex_pc_d    = pc_q;
        ex_instr_d = rd_instr;
        ex_a_d     = rd_data[0];
        ex_b_d     = rd_data[1];

        wb_valid_d = ex_valid_q;
        wb_we_d    = ex_we;
        wb_pc_d    = ex_pc_q;
        wb_instr_d = ex_instr_q;
        wb_addr_d  = ex_rw;
        wb_data_d  = alu_res;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            pc_q       <= '0;
            snap_q     <= '0;
            out_q      <= '0;
            ex_valid_q <= 1'b0;
            ex_pc_q    <= '0;
            ex_instr_q <= '0;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_pc_q    <= '0;
            wb_instr_q <= '0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            snap_q     <= snap_d;
            out_q      <= out_d;
            ex_valid_q <= ex_valid_d;
            ex_pc_q    <= ex_pc_d;
            ex_instr_q <= ex_instr_d;
            ex_a_q     <= ex_a_d;
            ex_b_q     <= ex_b_d;
            wb_valid_q <= wb_valid_d;
            wb_we_q    <= wb_we_d;
            wb_pc_q    <= wb_pc_d;
            wb_instr_q <= wb_instr_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
        end
    end

    // Memories keep their contents across reset
    always_ff @(posedge clk) begin
        if (imem_we) imem_q[imem_addr] <= imem_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset && wb_we_q) ram_q[wb_addr_q] <= wb_data_q;
    end

    assign outputs     = out_q;
    assign busy        = (state_q != StIdle);
    assign dbg_valid   = {wb_valid_q, ex_valid_q, rd_valid};
    assign dbg_pc      = {wb_pc_q, ex_pc_q, pc_q};
    assign dbg_instr   = {wb_instr_q, ex_instr_q, rd_instr};
    assign dbg_opcode  = {wb_instr_q[DATA_W-1 -: OP_W], ex_op, rd_op};
    assign dbg_op_a    = op_a;
    assign dbg_op_b    = op_b;
    assign dbg_wr_en   = wb_we_q;
    assign dbg_wr_addr = wb_addr_q;
    assign dbg_wr_data = wb_data_q;

endmodule

// File: tb/tb_dsp_core.sv
// Bench for dsp_core: directed timing/boundary steps plus random programs checked
// against a sequential instruction-level model of the program.
module tb_dsp_core;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [7:0][35:0]  inputs;
    logic [7:0][35:0]  outputs;
    logic              imem_we;
    logic [7:0]        imem_addr;
    logic [35:0]       imem_wdata;
    logic              busy;
    logic [2:0]        dbg_valid;
    logic [2:0][7:0]   dbg_pc;
    logic [2:0][35:0]  dbg_instr;
    logic [2:0][5:0]   dbg_opcode;
    logic [35:0]       dbg_op_a;
    logic [35:0]       dbg_op_b;
    logic              dbg_wr_en;
    logic [9:0]        dbg_wr_addr;
    logic [35:0]       dbg_wr_data;

    int checks = 0;
    int errors = 0;

    logic [35:0] prog   [256];
    logic [35:0] m_snap [8];
    logic [35:0] m_out  [8];
    logic [35:0] m_ram  [1024];

    dsp_core dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .inputs      (inputs),
        .outputs     (outputs),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .busy        (busy),
        .dbg_valid   (dbg_valid),
        .dbg_pc      (dbg_pc),
        .dbg_instr   (dbg_instr),
        .dbg_opcode  (dbg_opcode),
        .dbg_op_a    (dbg_op_a),
        .dbg_op_b    (dbg_op_b),
        .dbg_wr_en   (dbg_wr_en),
        .dbg_wr_addr (dbg_wr_addr),
        .dbg_wr_data (dbg_wr_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [35:0] enc(input int op, input int rw, input int ra, input int rb);
        return {6'(op), 10'(rw), 10'(ra), 10'(rb)};
    endfunction

    function automatic logic [35:0] enc_ldi(input int rw, input logic [19:0] imm);
        return {6'd8, 10'(rw), imm};
    endfunction

    task automatic load_prog(input int n);
        for (int i = 0; i < n; i++) begin
            imem_we    = 1'b1;
            imem_addr  = 8'(i);
            imem_wdata = prog[i];
            tick();
        end
        imem_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        check(tag, 36'(busy), 36'd0);
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < 8; i++) inputs[i] = {4'($urandom), 32'($urandom)};
    endtask

    function automatic logic [35:0] m_read(input logic [9:0] a);
        if (a < 10'd8) return m_snap[a[2:0]];
        if (a < 10'd16) return m_out[a[2:0]];
        return m_ram[a];
    endfunction

    // Sequential execution of the loaded program: one instruction at a time, no pipeline
    task automatic model_run();
        logic [35:0] ins, a, b, w;
        logic [5:0] op;
        logic [9:0] dst;
        logic signed [71:0] prod;
        bit wr;
        for (int i = 0; i < 8; i++) m_snap[i] = inputs[i];
        for (int pc = 0; pc < 256; pc++) begin
            ins = prog[pc];
            op  = ins[35:30];
            dst = ins[29:20];
            if (op == 6'd9) break;
            a  = m_read(ins[19:10]);
            b  = m_read(ins[9:0]);
            wr = 1'b1;
            w  = '0;
            case (op)
                6'd1: w = a + b;
                6'd2: w = a - b;
                6'd3: begin
                    prod = $signed({{36{a[35]}}, a}) * $signed({{36{b[35]}}, b});
                    prod = prod >>> 27;
                    w = prod[35:0];
                end
                6'd4: w = a & b;
                6'd5: w = a | b;
                6'd6: w = a ^ b;
                6'd7: w = a;
                6'd8: w = {{16{ins[19]}}, ins[19:0]};
                default: wr = 1'b0;
            endcase
            if (wr && dst >= 10'd8) begin
                if (dst < 10'd16) m_out[dst[2:0]] = w;
                else m_ram[dst] = w;
            end
        end
    endtask

    task automatic run_and_compare(input string tag);
        model_run();
        pulse_start();
        wait_idle({tag, "_idle"});
        for (int i = 0; i < 8; i++) check($sformatf("%s_out%0d", tag, i), outputs[i], m_out[i]);
    endtask

    function automatic int pick_addr();
        int r;
        r = int'($urandom_range(0, 23));
        return (r < 16) ? r : 32 + (r - 16);
    endfunction

    initial begin
        logic [35:0] v0, v1;
        int op;
        reset = 1'b0;
        start = 1'b0;
        imem_we = 1'b0;
        imem_addr = '0;
        imem_wdata = '0;
        inputs = '0;
        tick();
        tick();
        reset = 1'b1;

        // Idle after reset
        for (int i = 0; i < 5; i++) tick();
        check("rst_busy", 36'(busy), 36'd0);
        for (int i = 0; i < 8; i++) check($sformatf("rst_out%0d", i), outputs[i], 36'd0);

        // MOV out0 <- in0; HALT: latency and busy timing
        prog[0] = enc(7, 8, 0, 0);
        prog[1] = enc(9, 0, 0, 0);
        load_prog(2);
        rand_inputs();
        inputs[0] = 36'h400;
        pulse_start();
        check("mov_busy_c1", 36'(busy), 36'd1);
        tick();
        check("mov_ex_opcode_c2", 36'(dbg_opcode[1]), 36'd7);
        tick();
        check("mov_out_c3", outputs[0], 36'd0);
        tick();
        check("mov_out_c4", outputs[0], 36'h400);
        tick();
        check("mov_busy_c5", 36'(busy), 36'd0);

        // Back-to-back dependency chain, no stalls
        prog[0] = enc(1, 'h20, 0, 1);
        prog[1] = enc(1, 'h21, 'h20, 'h20);
        prog[2] = enc(7, 8, 'h21, 0);
        prog[3] = enc(9, 0, 0, 0);
        load_prog(4);
        inputs[0] = 36'h400;
        inputs[1] = 36'h800;
        pulse_start();
        for (int i = 0; i < 4; i++) tick();
        check("dep_out_c5", outputs[0], 36'h400);
        tick();
        check("dep_out_c6", outputs[0], 36'h1800);
        wait_idle("dep_idle");

        // Ten samples 27 cycles apart; input changes after start must not be seen
        prog[0] = enc(7, 8, 0, 0);
        prog[1] = enc(9, 0, 0, 0);
        load_prog(2);
        for (int s = 0; s < 10; s++) begin
            inputs[0] = 36'h500 + 36'(s) * 36'h100;
            pulse_start();
            inputs[0] = {4'($urandom), 32'($urandom)};
            for (int i = 0; i < 26; i++) tick();
            check($sformatf("sample%0d_out0", s), outputs[0], 36'h500 + 36'(s) * 36'h100);
        end

        // Arithmetic boundaries, ignored snapshot write, unknown opcode
        inputs[0] = 36'h4000000;
        inputs[1] = 36'h400;
        inputs[2] = 36'h7FFFFFFFF;
        inputs[3] = 36'h1;
        prog[0]  = enc(3, 8, 0, 1);
        prog[1]  = enc(1, 9, 2, 3);
        prog[2]  = enc_ldi(10, 20'hFFFFF);
        prog[3]  = enc(2, 11, 3, 2);
        prog[4]  = enc(63, 12, 0, 0);
        prog[5]  = enc(7, 3, 2, 0);
        prog[6]  = enc(7, 13, 3, 0);
        prog[7]  = enc_ldi('h30, 20'hFFFFE);
        prog[8]  = enc(3, 14, 'h30, 0);
        prog[9]  = enc_ldi(15, 20'h7FFFF);
        prog[10] = enc(9, 0, 0, 0);
        load_prog(11);
        pulse_start();
        wait_idle("arith_idle");
        check("mul_half", outputs[0], 36'h200);
        check("add_wrap", outputs[1], 36'h800000000);
        check("ldi_neg", outputs[2], 36'hFFFFFFFFF);
        check("sub_wrap", outputs[3], 36'h800000002);
        check("unknown_op_nowrite", outputs[4], 36'd0);
        check("snap_write_ignored", outputs[5], 36'h1);
        check("mul_neg", outputs[6], 36'hFFFFFFFFF);
        check("ldi_pos", outputs[7], 36'h7FFFF);

        // start mid-program: older WB lands, RD squashed, PC restarts
        reset = 1'b0;
        tick();
        reset = 1'b1;
        prog[0] = enc(1, 8, 8, 0);
        prog[1] = enc(1, 8, 8, 0);
        prog[2] = enc(1, 8, 8, 0);
        prog[3] = enc(9, 0, 0, 0);
        load_prog(4);
        inputs[0] = 36'h10;
        pulse_start();
        tick();
        inputs[0] = 36'h1000;
        pulse_start();
        check("restart_pc", 36'(dbg_pc[0]), 36'd0);
        check("restart_old_wb_en", 36'(dbg_wr_en), 36'd1);
        check("restart_old_wb_addr", 36'(dbg_wr_addr), 36'h8);
        wait_idle("restart_idle");
        check("restart_out0", outputs[0], 36'h3010);

        // reset mid-run: outputs cleared, no later write
        inputs[0] = 36'h5;
        pulse_start();
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("midrst_out0", outputs[0], 36'd0);
        check("midrst_busy", 36'(busy), 36'd0);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("midrst_out0_later", outputs[0], 36'd0);
        check("midrst_busy_later", 36'(busy), 36'd0);

        // Instruction memory survives reset
        inputs[0] = 36'h7;
        pulse_start();
        wait_idle("imem_keep_idle");
        check("imem_keep_out0", outputs[0], 36'h15);

        // reset wins over start
        reset = 1'b0;
        start = 1'b1;
        tick();
        reset = 1'b1;
        start = 1'b0;
        check("rst_start_busy", 36'(busy), 36'd0);
        tick();
        check("rst_start_busy2", 36'(busy), 36'd0);

        // No HALT: run stops after the last instruction address
        for (int i = 0; i < 254; i++) prog[i] = '0;
        prog[254] = enc(7, 9, 1, 0);
        prog[255] = enc(7, 8, 0, 0);
        load_prog(256);
        rand_inputs();
        v0 = inputs[0];
        v1 = inputs[1];
        pulse_start();
        wait_idle("pcend_idle");
        check("pcend_out0", outputs[0], v0);
        check("pcend_out1", outputs[1], v1);

        // Random programs against the model
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) m_out[i] = '0;
        for (int k = 0; k < 8; k++) prog[k] = enc_ldi(32 + k, 20'($urandom));
        prog[8] = enc(9, 0, 0, 0);
        load_prog(9);
        rand_inputs();
        run_and_compare("rinit");
        for (int t = 0; t < 6; t++) begin
            for (int k = 0; k < 24; k++) begin
                op = int'($urandom_range(0, 11));
                if (op == 9) op = 3;
                if (op >= 10) op = (op == 10) ? 20 : 63;
                prog[k] = enc(op, pick_addr(), pick_addr(), pick_addr());
            end
            prog[24] = enc(9, 0, 0, 0);
            load_prog(25);
            rand_inputs();
            run_and_compare($sformatf("rand%0d", t));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dsp_core.md
Name: dsp_core

Overview:
- Small programmable DSP engine that runs one short program per audio sample.
- A start pulse snapshots eight 36-bit input channels and runs the program from address 0 through a 3-stage pipeline (RD read/fetch, EX execute, WB write-back).
- The program updates eight 36-bit output registers.
- Sits between the sample-rate input/output framers of the mixer datapath.

Parameters:
- DATA_W, 36: data and instruction word width.
- N_IO, 8: number of input channels and number of output channels.
- IMEM_AW, 8: instruction memory address width (256 words).
- DMEM_AW, 10: data memory address width (1024 words); matches the instruction operand fields.
- FRAC_BITS, 27: fractional bits used by MUL.

Ports:
- clk, in, 1: single clock; all logic on its rising edge.
- reset, in, 1: synchronous, active-low reset.
- start, in, 1: one-cycle pulse; begins processing of a new sample.
- inputs, in, N_IO x DATA_W: input sample channels.
- outputs, out, N_IO x DATA_W: output sample channels (registered).
- imem_we, in, 1: instruction memory write enable.
- imem_addr, in, IMEM_AW: instruction memory write address.
- imem_wdata, in, DATA_W: instruction word to write.
- busy, out, 1: high from start until the pipeline has drained after HALT.

Behaviour:
- Instruction format: [35:30] opcode, [29:20] rw (dest), [19:10] ra, [9:0] rb.
- Data memory map:
  - 0x000-0x007 read the input snapshot; writes there are ignored.
  - 0x008-0x00F are the output registers; readable, and a write updates outputs[addr-8].
  - All other addresses are general RAM.
  - Two read ports and one write port.
- Opcodes:
  - 0 NOP.
  - 1 ADD: w=a+b.
  - 2 SUB: w=a-b.
  - 3 MUL: w=(signed a * signed b)>>>FRAC_BITS, low 36 bits kept.
  - 4 AND, 5 OR, 6 XOR.
  - 7 MOV: w=a.
  - 8 LDI: w=sign-extended {ra,rb} (20-bit immediate).
  - 9 HALT.
  - All other opcodes execute as NOP (no write).
- Arithmetic is two's complement and wraps modulo 2^36; there is no saturation.
- Reset (reset=0 at a clock edge):
  - PC=0, all stage valid bits=0, busy=0, outputs all 0, state IDLE.
  - RAM contents and instruction memory are preserved.
- States:
  - IDLE: no instruction issue. start moves to RUN.
  - RUN: one instruction fetched per cycle, PC increments. Fetching HALT, or PC reaching 2^IMEM_AW-1, moves to DRAIN. HALT itself performs no write.
  - DRAIN: instructions already in EX/WB complete; then IDLE and busy=0.
- On start (any state):
  - The input snapshot captures inputs on that edge.
  - PC<=0 and the RD stage is squashed.
  - Instructions already in EX/WB still complete.
- Timing: instruction 0 is in RD the cycle after start, in EX the next cycle, and written in WB the cycle after. An output write appears on outputs the cycle after its WB.
- Forwarding, with no stalls ever:
  - EX operands take the WB result when WB's rw equals the operand address and WB writes.
  - A RD-stage read of an address being written in the same cycle returns the new data (write-first).
  - Back-to-back dependent instructions therefore see correct values.
- imem writes are allowed at any time. Writing the address currently being fetched has undefined effect on that fetch; software loads only while busy=0.
- start and reset together: reset wins.
- outputs hold their value between samples until rewritten.
- Debug visibility: pipeline registers PC, instruction and opcode per stage; forwarded EX operands; write enable, address and data.

Test Plan:
- Reset, then no start: outputs all 0 and busy=0 after 5 idle cycles.
- Program {MOV 0x008<-0x000; HALT}, inputs[0]=0x400, start: outputs[0]=0x400 at start+4; busy drops by start+5.
- Dependency chain {ADD 0x020<-0x000,0x001; ADD 0x021<-0x020,0x020; MOV 0x008<-0x021; HALT}, inputs 0x400 and 0x800: outputs[0]=0x1800, with no stall cycles.
- Ten consecutive samples 27 cycles apart, inputs[0] incremented by 0x100 each time (0x500, 0x600, ...), program copies input 0 to output 0: each output value matches that sample's snapshot; an input change after start is not seen.
- MUL 0.5 (0x4000000) by 0x400 -> 0x200; ADD 0x7FFFFFFFF+1 -> 0x800000000 (wrap); LDI 0xFFFFF -> 0xFFFFFFFFF.
- start asserted mid-program: PC restarts at 0 and the older in-flight WB still lands. reset=0 mid-run: outputs go to 0 and there is no further write.
